busca_instrucao: RTL and testbench

Instruction-fetch sequencer for the reduced MIPS datapath, the initiator that feeds opcodes into the `controle` decoder. Holds the program counter, fetches 16-bit instruction words from instruction memory via a req/ack handshake, latches them in the instruction register, and presents `opcode` to `controle`. On execution completion it uses `branch`/`jump` from `controle` and the ULA `zero` flag to pick the next PC.

---
 rtl/mips_pkg.sv | 18 +
 rtl/busca_instrucao_if.sv | 27 ++
 rtl/proximo_pc.sv | 38 +++
 rtl/busca_instrucao.sv | 93 +++++++++
 tb/tb_busca_instrucao.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the reduced MIPS datapath: instruction field positions
// and the encodings of the fetch sequencer's states.
package mips_pkg;

  localparam int OPCODE_W   = 3;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;
  localparam int IMM7_MSB   = 6;
  localparam int IMM7_LSB   = 0;

  // 2'b11 is never entered; the sequencer treats it exactly like OCIOSO.
  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    BUSCA   = 2'b01,
    EXECUTA = 2'b10
  } estado_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Instruction-memory read port: a req/ack handshake with the data valid in the ack cycle.
interface busca_instrucao_if #(
  parameter int LARGURA_PC    = 8,
  parameter int LARGURA_INSTR = 16
) ();

  logic                     mem_req;
  logic [LARGURA_PC-1:0]    mem_endereco;
  logic                     mem_ack;
  logic [LARGURA_INSTR-1:0] mem_dado;

  // The fetch unit is the initiator; the instruction memory answers.
  modport master (
    output mem_req,
    output mem_endereco,
    input  mem_ack,
    input  mem_dado
  );

  modport slave (
    input  mem_req,
    input  mem_endereco,
    output mem_ack,
    output mem_dado
  );

endinterface

// File: rtl/proximo_pc.sv
// Next-PC selection: jump target over taken branch over sequential, all
// arithmetic wrapping modulo 2^LARGURA_PC.
module proximo_pc
  import mips_pkg::*;
#(
  parameter int LARGURA_PC    = 8,
  parameter int LARGURA_INSTR = 16
) (
  input  logic [LARGURA_PC-1:0]    pc_i,
  input  logic [LARGURA_INSTR-1:0] ir_i,
  input  logic                     branch_i,
  input  logic                     jump_i,
  input  logic                     zero_i,
  output logic [LARGURA_PC-1:0]    pc_prox_o
);

  logic [LARGURA_PC-1:0] pc_mais_um;
  logic [LARGURA_PC-1:0] deslocamento;
  logic [LARGURA_PC-1:0] alvo;
  logic                  unused_ir;

  // The size cast sign-extends imm7 for wide PCs and truncates it for narrow ones.
  assign deslocamento = LARGURA_PC'(signed'(ir_i[IMM7_MSB:IMM7_LSB]));
  assign alvo         = ir_i[LARGURA_PC-1:0];
  assign pc_mais_um   = pc_i + LARGURA_PC'(1);
  assign unused_ir    = ^ir_i;

  always_comb begin
    if (jump_i) begin
      pc_prox_o = alvo;
    end else if (branch_i && zero_i) begin
      pc_prox_o = pc_mais_um + deslocamento;
    end else begin
      pc_prox_o = pc_mais_um;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch sequencer: owns PC, IR and the retired-instruction count,
// fetching over a req/ack port and feeding the opcode to the decoder.
module busca_instrucao
  import mips_pkg::*;
#(
  parameter int LARGURA_PC    = 8,
  parameter int LARGURA_INSTR = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  busca_instrucao_if.master        mem,
  input  logic                     habilita,
  output logic [OPCODE_W-1:0]      opcode,
  output logic [LARGURA_INSTR-1:0] ir,
  output logic                     instr_valida,
  input  logic                     branch,
  input  logic                     jump,
  input  logic                     zero,
  input  logic                     avanca,
  output logic [LARGURA_PC-1:0]    pc,
  output logic [15:0]              contador_instr
);

  estado_t                  estado_q, estado_d;
  logic [LARGURA_PC-1:0]    pc_q, pc_d;
  logic [LARGURA_INSTR-1:0] ir_q, ir_d;
  logic [15:0]              contador_q, contador_d;
  logic [LARGURA_PC-1:0]    pc_prox;

  proximo_pc #(
    .LARGURA_PC    (LARGURA_PC),
    .LARGURA_INSTR (LARGURA_INSTR)
  ) u_proximo_pc (
    .pc_i      (pc_q),
    .ir_i      (ir_q),
    .branch_i  (branch),
    .jump_i    (jump),
    .zero_i    (zero),
    .pc_prox_o (pc_prox)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one unassigned and infers a latch.
    estado_d   = estado_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    contador_d = contador_q;

    case (estado_q)
      BUSCA: begin
        if (mem.mem_ack) begin
          ir_d     = mem.mem_dado;
          estado_d = EXECUTA;
        end
      end
      EXECUTA: begin
        if (avanca) begin
          pc_d       = pc_prox;
          contador_d = contador_q + 16'd1;
          estado_d   = habilita ? BUSCA : OCIOSO;
        end
      end
      default: begin
        estado_d = habilita ? BUSCA : OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      pc_q       <= '0;
      ir_q       <= '0;
      contador_q <= '0;
    end else begin
      // NOTE: state updates use <= so every register samples the pre-edge values of the others.
      estado_q   <= estado_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      contador_q <= contador_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign mem.mem_req      = (estado_q == BUSCA);
  assign mem.mem_endereco = pc_q;
  assign instr_valida     = (estado_q == EXECUTA);
  assign opcode           = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign ir               = ir_q;
  assign pc               = pc_q;
  assign contador_instr   = contador_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: fetch cadence, next-PC rules, wait states,
// asynchronous reset and run-enable handling.
`timescale 1ns/1ps
module tb_busca_instrucao;

  logic        clock;
  logic        reset;
  logic        habilita;
  logic [2:0]  opcode;
  logic [15:0] ir;
  logic        instr_valida;
  logic        branch;
  logic        jump;
  logic        zero;
  logic        avanca;
  logic [7:0]  pc;
  logic [15:0] contador_instr;

  int n_assert = 0;
  int n_fail   = 0;

  busca_instrucao_if #(.LARGURA_PC(8), .LARGURA_INSTR(16)) bus ();

  busca_instrucao #(.LARGURA_PC(8), .LARGURA_INSTR(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem            (bus),
    .habilita       (habilita),
    .opcode         (opcode),
    .ir             (ir),
    .instr_valida   (instr_valida),
    .branch         (branch),
    .jump           (jump),
    .zero           (zero),
    .avanca         (avanca),
    .pc             (pc),
    .contador_instr (contador_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One instruction from a BUSCA cycle: ack at once, then retire with the given controls.
  task automatic rodada(input logic [15:0] dado, input logic br, input logic jp, input logic z);
    bus.mem_dado = dado;
    bus.mem_ack  = 1'b1;
    avanca       = 1'b0;
    step();
    bus.mem_ack = 1'b0;
    branch      = br;
    jump        = jp;
    zero        = z;
    avanca      = 1'b1;
    step();
    branch = 1'b0;
    jump   = 1'b0;
    zero   = 1'b0;
    avanca = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " mem_req"}, 32'(bus.mem_req), 32'h0);
    check({tag, " instr_valida"}, 32'(instr_valida), 32'h0);
    check({tag, " pc"}, 32'(pc), 32'h0);
    check({tag, " endereco"}, 32'(bus.mem_endereco), 32'h0);
    check({tag, " opcode"}, 32'(opcode), 32'h0);
    check({tag, " ir"}, 32'(ir), 32'h0);
    check({tag, " contador"}, 32'(contador_instr), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    habilita     = 1'b0;
    branch       = 1'b0;
    jump         = 1'b0;
    zero         = 1'b0;
    avanca       = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_dado = 16'h0000;
    #1;
    check_reset_values("reset");

    #20 reset = 1'b1;

    // Back-to-back execution: ack and avanca held high, two cycles per instruction.
    habilita     = 1'b1;
    bus.mem_ack  = 1'b1;
    bus.mem_dado = 16'h2000;
    avanca       = 1'b1;
    step();
    check("first busca mem_req", 32'(bus.mem_req), 32'h1);
    check("first busca endereco", 32'(bus.mem_endereco), 32'h0);
    check("first busca instr_valida", 32'(instr_valida), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("seq instr_valida", 32'(instr_valida), 32'h1);
      check("seq opcode", 32'(opcode), 32'h1);
      check("seq pc in executa", 32'(pc), 32'(k));
      check("seq contador", 32'(contador_instr), 32'(k));
      step();
      check("seq mem_req", 32'(bus.mem_req), 32'h1);
      check("seq endereco", 32'(bus.mem_endereco), 32'(k + 1));
      check("seq contador after avanca", 32'(contador_instr), 32'(k + 1));
    end
    bus.mem_ack = 1'b0;
    avanca      = 1'b0;

    // Branch not taken, then taken with imm7 = -4 from pc 0x10.
    rodada(16'h0010, 1'b0, 1'b1, 1'b0);
    check("jump to 0x10", 32'(pc), 32'h10);
    rodada(16'h407C, 1'b1, 1'b0, 1'b0);
    check("branch zero=0 sequential", 32'(pc), 32'h11);
    rodada(16'h0010, 1'b0, 1'b1, 1'b0);
    check("jump back to 0x10", 32'(pc), 32'h10);
    rodada(16'h407C, 1'b1, 1'b0, 1'b1);
    check("branch taken -4", 32'(pc), 32'h0D);
    check("branch taken endereco", 32'(bus.mem_endereco), 32'h0D);

    // Jump wins over a taken branch; sequential and branch arithmetic wrap.
    rodada(16'h00A5, 1'b1, 1'b1, 1'b1);
    check("jump priority", 32'(pc), 32'hA5);
    rodada(16'h00FF, 1'b0, 1'b1, 1'b0);
    check("jump to 0xFF", 32'(pc), 32'hFF);
    rodada(16'h2000, 1'b0, 1'b0, 1'b0);
    check("sequential wrap", 32'(pc), 32'h00);
    rodada(16'h407C, 1'b1, 1'b0, 1'b1);
    check("branch underflow wrap", 32'(pc), 32'hFD);
    check("contador after rounds", 32'(contador_instr), 32'd12);

    // Fetch wait states: five cycles without ack.
    bus.mem_dado = 16'h6123;
    for (int k = 0; k < 5; k++) begin
      step();
      check("wait busca mem_req", 32'(bus.mem_req), 32'h1);
      check("wait busca endereco", 32'(bus.mem_endereco), 32'hFD);
    end
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("fetch after wait ir", 32'(ir), 32'h6123);
    check("fetch after wait opcode", 32'(opcode), 32'h3);

    // Execute wait states: controls toggled but avanca low must change nothing.
    branch = 1'b1;
    jump   = 1'b1;
    zero   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("wait executa ir", 32'(ir), 32'h6123);
      check("wait executa pc", 32'(pc), 32'hFD);
      check("wait executa instr_valida", 32'(instr_valida), 32'h1);
    end
    avanca = 1'b1;
    step();
    avanca = 1'b0;
    branch = 1'b0;
    jump   = 1'b0;
    zero   = 1'b0;
    check("jump after wait", 32'(pc), 32'h23);
    check("contador after wait", 32'(contador_instr), 32'd13);

    // Dropping habilita in the avanca cycle parks in OCIOSO with pc updated.
    bus.mem_dado = 16'h2000;
    bus.mem_ack  = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    habilita    = 1'b0;
    avanca      = 1'b1;
    step();
    avanca = 1'b0;
    check("ocioso mem_req", 32'(bus.mem_req), 32'h0);
    check("ocioso instr_valida", 32'(instr_valida), 32'h0);
    check("ocioso pc", 32'(pc), 32'h24);
    check("ocioso contador", 32'(contador_instr), 32'd14);
    step();
    check("ocioso held mem_req", 32'(bus.mem_req), 32'h0);
    habilita = 1'b1;
    step();
    check("resume mem_req", 32'(bus.mem_req), 32'h1);
    check("resume endereco", 32'(bus.mem_endereco), 32'h24);

    // Asynchronous reset in the middle of BUSCA.
    #2 reset = 1'b0;
    #1;
    check_reset_values("reset in busca");
    #2 reset = 1'b1;
    step();
    check("after reset busca", 32'(bus.mem_req), 32'h1);
    rodada(16'h2000, 1'b0, 1'b0, 1'b0);
    bus.mem_dado = 16'hE000;
    bus.mem_ack  = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("pre-reset instr_valida", 32'(instr_valida), 32'h1);
    check("pre-reset opcode", 32'(opcode), 32'h7);
    check("pre-reset contador", 32'(contador_instr), 32'd1);

    // Asynchronous reset in the middle of EXECUTA.
    #2 reset = 1'b0;
    #1;
    check_reset_values("reset in executa");
    #2 reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
